lfsr_arbiter: RTL and testbench
===============================

Name: lfsr_arbiter

Overview:
Owns one 5-bit Fibonacci LFSR and shares it between two requesters through a req/ack handshake with round-robin arbitration. It also runs a programmable free-run tick that keeps the sequence advancing when idle, and supports seed loading with zero lock-up protection. It sits between the shared pseudo-random source and consumer blocks such as the noise and modulation paths, which need independent draws from one generator.

Parameters:
TICK_DIV, 4, free-run step period in clk cycles; 0 disables free-run stepping.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  2  request lines; bit i belongs to requester i; level, held until ack
seed_load  input  1  one-cycle strobe to load seed_in into the LFSR
seed_in  input  5  seed value
ack  output  2  one-cycle acknowledge pulse per requester, registered
rand_out  output  5  random value delivered; valid while any ack bit is high
lfsr_q  output  5  current LFSR state, for observation only

Behaviour:
- LFSR step rule: next = {q[0]^q[2], q[4:1]}. Maximal length, period 31; state 0 is never reachable.
- Reset, sampled on the clk edge:
  - lfsr = 5'b00001, ack = 0, rand_out = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins first.
  - Tick counter = 0.
- Priority order each cycle: reset > seed_load > grant > free-run tick.
- Seed load:
  - lfsr <= seed_in, or 5'b00001 if seed_in == 0.
  - No grant is issued that cycle; pending reqs stay pending. ack = 0 next cycle.
  - Tick counter restarts at 0.
- Eligibility: requester i is eligible when req[i]=1 and ack[i]=0 in the current cycle. A requester is therefore never double-served on a held req.
- Grant:
  - One eligible requester: grant it.
  - Both eligible: grant the one != last_grant.
  - On grant to requester g in cycle N:
    - Cycle N+1: ack[g]=1, other ack bit 0, rand_out = lfsr value at cycle N (pre-step).
    - lfsr <= next; last_grant <= g.
  - Latency is req to ack in 1 cycle when uncontended.
  - Requester must drop req in the cycle its ack is high, or it is served again two cycles later.
- No grant: ack <= 0; rand_out holds its last value.
- Free-run tick (TICK_DIV > 0):
  - Counter counts 0..TICK_DIV-1 and wraps.
  - At wrap, lfsr steps only if no grant and no seed_load occur that cycle; otherwise the tick is absorbed, giving at most one step per cycle.
  - Counter runs continuously except for the restart on seed_load.
- Throughput:
  - Both requesters held: grants alternate 0,1,0,1, one per cycle.
  - Single requester held: one grant every 2 cycles.
- Reset mid-handshake: ack clears next cycle and any in-flight grant is dropped. Requesters must re-present req after reset.
- lfsr_q is combinationally equal to the internal state register.

Test Plan:
- TICK_DIV=0. Reset, then pulse req[0] for 1 cycle -> ack[0]=1 one cycle later, rand_out=0x01, lfsr_q=0x10. Repeat -> rand_out=0x10, then 0x08, 0x04, 0x12, 0x09.
- TICK_DIV=0. After reset, hold req=2'b11 for 6 cycles -> ack sequence 01,10,01,10,01,10 with rand_out 0x01,0x10,0x08,0x04,0x12,0x09.
- TICK_DIV=0. Hold req[1] only -> ack[1] every other cycle; rand_out follows the sequence with no skipped values.
- seed_load with seed_in=0 -> lfsr_q=0x01. seed_load with seed_in=0x14 while req[0]=1 -> no ack that cycle; next cycle grant gives rand_out=0x14.
- TICK_DIV=4, req=0 -> lfsr_q steps every 4 cycles (0x01 -> 0x10 after the 4th edge). Run 124 cycles -> lfsr_q returns to 0x01, with 31 distinct nonzero states.
- Reset asserted in the cycle ack[0]=1 -> next cycle ack=0, rand_out=0, lfsr_q=0x01, and requester 0 wins the next contested grant.

Source files
------------

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: one 5-bit Fibonacci LFSR shared by two requesters via round-robin req/ack,
// with a programmable free-run tick and zero-safe seed loading.
module lfsr_arbiter #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       seed_load,
    input  logic [4:0] seed_in,
    output logic [1:0] ack,
    output logic [4:0] rand_out,
    output logic [4:0] lfsr_q
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(TICK_DIV > 0 ? TICK_DIV - 1 : 0);

    logic [4:0]    state_q, state_d, step, rand_q, rand_d;
    logic [1:0]    ack_q, ack_d, elig;
    logic          last_q, last_d, gnt, g, wrap;
    logic [CW-1:0] cnt_q, cnt_d;

    assign step = {state_q[0] ^ state_q[2], state_q[4:1]};
    // a requester just acked is not eligible, so a held req is never served back-to-back
    assign elig = req & ~ack_q;
    assign gnt  = |elig;
    assign g    = &elig ? ~last_q : elig[1];
    assign wrap = (TICK_DIV > 0) && (cnt_q == TOP);

    always_comb begin
        cnt_d   = (seed_load || wrap || TICK_DIV == 0) ? '0 : cnt_q + 1'b1;
        state_d = seed_load ? (seed_in == '0 ? 5'd1 : seed_in) : (gnt || wrap) ? step : state_q;
        ack_d   = (seed_load || !gnt) ? 2'b00 : (g ? 2'b10 : 2'b01);
        rand_d  = (!seed_load && gnt) ? state_q : rand_q;
        last_d  = (!seed_load && gnt) ? g : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 5'd1;
            ack_q   <= 2'b00;
            rand_q  <= 5'd0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rand_q  <= rand_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign rand_out = rand_q;
    assign lfsr_q   = state_q;
endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb_lfsr_arbiter: directed scoreboard bench for lfsr_arbiter (TICK_DIV=0 and TICK_DIV=4 instances).
module tb_lfsr_arbiter;
    typedef struct packed {
        logic [1:0] ack;
        logic [4:0] rnd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r0, sl0, r4, sl4;
    logic [1:0] req0, ack0, req4, ack4;
    logic [4:0] si0, rnd0, lq0, si4, rnd4, lq4;

    lfsr_arbiter #(.TICK_DIV(0)) dut0 (
        .clk(clk), .reset(r0), .req(req0), .seed_load(sl0), .seed_in(si0),
        .ack(ack0), .rand_out(rnd0), .lfsr_q(lq0)
    );
    lfsr_arbiter #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(r4), .req(req4), .seed_load(sl4), .seed_in(si4),
        .ack(ack4), .rand_out(rnd4), .lfsr_q(lq4)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [4:0] seq [0:7] = '{5'h01, 5'h10, 5'h08, 5'h04, 5'h12, 5'h09, 5'h14, 5'h1A};

    function automatic logic [4:0] nxt(input logic [4:0] s);
        return {s[0] ^ s[2], s[4:1]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed_ack=%0h", tag, ack0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ack"}, {6'd0, ack0}, {6'd0, e.ack});
            chk({tag, "_rand"}, {3'd0, rnd0}, {3'd0, e.rnd});
        end
    endtask

    initial begin
        logic [4:0]  m;
        logic [31:0] seen;
        int          distinct;
        r0 = 1'b1; req0 = 2'b00; sl0 = 1'b0; si0 = 5'd0;
        r4 = 1'b1; req4 = 2'b00; sl4 = 1'b0; si4 = 5'd0;
        tick;
        tick;
        r0 = 1'b0;
        chk("rst_ack", {6'd0, ack0}, 8'h00);
        chk("rst_rand", {3'd0, rnd0}, 8'h00);
        chk("rst_lfsr", {3'd0, lq0}, 8'h01);
        // single-cycle pulses on requester 0
        for (int i = 0; i < 6; i++) begin
            req0 = 2'b01;
            sb.push_back({2'b01, seq[i]});
            tick;
            req0 = 2'b00;
            pop_chk("t1");
            chk("t1_lfsr", {3'd0, lq0}, {3'd0, seq[i+1]});
            tick;
            chk("t1_idle_ack", {6'd0, ack0}, 8'h00);
        end
        // both requesters held: strict alternation starting at 0
        r0 = 1'b1;
        tick;
        r0 = 1'b0;
        req0 = 2'b11;
        for (int i = 0; i < 6; i++) begin
            sb.push_back({(i % 2 != 0) ? 2'b10 : 2'b01, seq[i]});
            tick;
            pop_chk("t2");
        end
        req0 = 2'b00;
        tick;
        chk("t2_drop_ack", {6'd0, ack0}, 8'h00);
        chk("t2_hold_rand", {3'd0, rnd0}, {3'd0, seq[5]});
        // requester 1 alone: grant every other cycle, no skipped values
        r0 = 1'b1;
        tick;
        r0 = 1'b0;
        req0 = 2'b10;
        for (int i = 0; i < 8; i++) begin
            sb.push_back({(i % 2 != 0) ? 2'b00 : 2'b10, seq[i/2]});
            tick;
            pop_chk("t3");
        end
        req0 = 2'b00;
        tick;
        chk("t3_lfsr", {3'd0, lq0}, {3'd0, seq[4]});
        // seed loading, zero protection, and grant suppression
        sl0 = 1'b1; si0 = 5'h00;
        tick;
        sl0 = 1'b0;
        chk("t4_zero_seed", {3'd0, lq0}, 8'h01);
        chk("t4_zero_ack", {6'd0, ack0}, 8'h00);
        sl0 = 1'b1; si0 = 5'h14; req0 = 2'b01;
        tick;
        sl0 = 1'b0;
        chk("t4_seed_noack", {6'd0, ack0}, 8'h00);
        chk("t4_seed_lfsr", {3'd0, lq0}, 8'h14);
        sb.push_back({2'b01, 5'h14});
        tick;
        pop_chk("t4_grant");
        chk("t4_post_lfsr", {3'd0, lq0}, 8'h1A);
        req0 = 2'b00;
        tick;
        // reset in the cycle ack[0] is high
        r0 = 1'b1;
        tick;
        r0 = 1'b0;
        req0 = 2'b01;
        tick;
        chk("t6_pre_ack", {6'd0, ack0}, 8'h01);
        r0 = 1'b1;
        req0 = 2'b00;
        tick;
        r0 = 1'b0;
        chk("t6_ack", {6'd0, ack0}, 8'h00);
        chk("t6_rand", {3'd0, rnd0}, 8'h00);
        chk("t6_lfsr", {3'd0, lq0}, 8'h01);
        req0 = 2'b11;
        tick;
        chk("t6_contest_ack", {6'd0, ack0}, 8'h01);
        chk("t6_contest_rand", {3'd0, rnd0}, 8'h01);
        req0 = 2'b00;
        tick;
        // free-run tick on the TICK_DIV=4 instance
        r4 = 1'b0;
        m = 5'h01;
        seen = '0;
        for (int c = 1; c <= 124; c++) begin
            tick;
            if (c % 4 == 0) m = nxt(m);
            chk("t5_lfsr", {3'd0, lq4}, {3'd0, m});
            seen[lq4] = 1'b1;
        end
        distinct = 0;
        for (int k = 0; k < 32; k++) if (seen[k]) distinct++;
        chk("t5_distinct", 8'(distinct), 8'd31);
        chk("t5_no_zero", {7'd0, seen[0]}, 8'h00);
        chk("t5_wrap", {3'd0, lq4}, 8'h01);
        chk("t5_ack", {6'd0, ack4}, 8'h00);
        chk("t5_sb_empty", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
